// File: rtl/bcd_scan_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_scan_counter
// Purpose  : NUM_DIGITS-wide BCD up/down counter with parallel load. Its
//            digits are time-multiplexed onto one 4-bit BCD bus with a
//            one-hot digit select, so a single set of seven-segment decoders
//            can drive a multi-digit display. Optional leading-zero blanking.
// Ports    : clk        rising-edge system clock
//            reset      synchronous active-high reset
//            en         count enable, one step per cycle
//            up         direction (1 = increment, 0 = decrement)
//            load       parallel load strobe (has priority over en)
//            load_val   BCD load value, digit 0 in bits [3:0]
//            count      registered counter value, digit 0 least significant
//            wrap       one-cycle pulse on full-range rollover
//            bcd_out    BCD code of the scanned digit (bit 3 = decoder in1)
//            digit_sel  one-hot enable of the scanned digit
//            blank      scanned digit is a suppressed leading zero
// Revision : 1.0 - initial release
// ============================================================================
module bcd_scan_counter #(
  parameter int NUM_DIGITS = 4,    // 1..8
  parameter int SCAN_DIV   = 1000, // cycles per displayed digit, >= 2
  parameter int LZB        = 1     // 1 = leading-zero blanking enabled
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    wrap,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    blank
);

  // --------------------------------------------------------------------------
  // Derived widths
  // --------------------------------------------------------------------------
  localparam int CW    = 4 * NUM_DIGITS;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_RST  = NUM_DIGITS'(1);
  localparam logic [3:0]            BCD_MAX  = 4'd9;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  logic [CW-1:0]         count_q,  count_d;
  logic                  wrap_q,   wrap_d;
  logic [PRE_W-1:0]      pre_q,    pre_d;
  logic [IDX_W-1:0]      idx_q,    idx_d;
  logic [NUM_DIGITS-1:0] sel_q,    sel_d;
  logic [3:0]            bcd_q,    bcd_d;
  logic                  blank_q,  blank_d;

  // --------------------------------------------------------------------------
  // Load path: clamp any illegal nibble to 9 so the counter can never hold a
  // non-BCD digit, whatever the load source presents.
  // --------------------------------------------------------------------------
  logic [CW-1:0] w_load_clamped;

  always_comb begin
    w_load_clamped = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load_val[4*i +: 4] > BCD_MAX) begin
        w_load_clamped[4*i +: 4] = BCD_MAX;
      end else begin
        w_load_clamped[4*i +: 4] = load_val[4*i +: 4];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Ripple step: a single carry/borrow flag walks from digit 0 upward. Once
  // it is absorbed by a digit, higher digits pass through unchanged. A flag
  // still set after the top digit means the whole range rolled over.
  // --------------------------------------------------------------------------
  logic [CW-1:0] w_step;
  logic          w_step_wrap;
  logic          w_ripple;
  logic [3:0]    w_digit;

  always_comb begin
    w_step   = count_q;
    w_ripple = 1'b1;
    w_digit  = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_digit = count_q[4*i +: 4];
      if (w_ripple) begin
        if (up) begin
          // Treat >=9 as the carry case; digits never exceed 9, but this
          // keeps the step closed over BCD even if one ever did.
          if (w_digit >= BCD_MAX) begin
            w_step[4*i +: 4] = 4'd0;
          end else begin
            w_step[4*i +: 4] = w_digit + 4'd1;
            w_ripple         = 1'b0;
          end
        end else begin
          if (w_digit == 4'd0) begin
            w_step[4*i +: 4] = BCD_MAX;
          end else if (w_digit > BCD_MAX) begin
            w_step[4*i +: 4] = BCD_MAX - 4'd1;
            w_ripple         = 1'b0;
          end else begin
            w_step[4*i +: 4] = w_digit - 4'd1;
            w_ripple         = 1'b0;
          end
        end
      end
    end
    w_step_wrap = w_ripple;
  end

  // --------------------------------------------------------------------------
  // Counter next state: load beats en; reset is handled in the register.
  // --------------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = w_load_clamped;
    end else if (en) begin
      count_d = w_step;
      wrap_d  = w_step_wrap;
    end
  end

  // --------------------------------------------------------------------------
  // Scan timing: free-running prescaler, independent of en/load. The digit
  // index advances on the prescaler's terminal count.
  // --------------------------------------------------------------------------
  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    idx_d = idx_q;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scan outputs are all computed from the *next* index and the current
  // count, then registered together. That keeps digit_sel, bcd_out and blank
  // consistent on every cycle, and lets a digit that changes mid-slot show up
  // one cycle later rather than waiting for the next slot.
  // --------------------------------------------------------------------------
  always_comb begin
    sel_d = '0;
    bcd_d = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        sel_d[i] = 1'b1;
        bcd_d    = count_q[4*i +: 4];
      end
    end
  end

  generate
    if (LZB != 0) begin : g_lzb_on
      logic w_zero_above;

      // Walk from the most significant digit down; w_zero_above tracks
      // whether the scanned digit and every digit above it are zero.
      // Digit 0 is excluded so a zero value still displays "0".
      always_comb begin
        blank_d      = 1'b0;
        w_zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
          w_zero_above = w_zero_above & (count_q[4*i +: 4] == 4'd0);
          if ((idx_d == IDX_W'(i)) && (i != 0)) begin
            blank_d = w_zero_above;
          end
        end
      end
    end else begin : g_lzb_off
      assign blank_d = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      pre_q   <= '0;
      idx_q   <= '0;
      sel_q   <= SEL_RST;
      bcd_q   <= 4'd0;
      blank_q <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      bcd_q   <= bcd_d;
      blank_q <= blank_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign count     = count_q;
  assign wrap      = wrap_q;
  assign bcd_out   = bcd_q;
  assign digit_sel = sel_q;
  assign blank     = blank_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_scan_counter
// Purpose  : Directed self-checking bench for bcd_scan_counter with
//            NUM_DIGITS=4, SCAN_DIV=4. A second instance with LZB=0 shares
//            the stimulus to confirm blanking stays off.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_scan_counter;

  localparam int ND  = 4;
  localparam int DIV = 4;

  logic          clk;
  logic          reset;
  logic          en;
  logic          up;
  logic          load;
  logic [15:0]   load_val;
  logic [15:0]   count;
  logic          wrap;
  logic [3:0]    bcd_out;
  logic [ND-1:0] digit_sel;
  logic          blank;

  logic [15:0]   count_n;
  logic          wrap_n;
  logic [3:0]    bcd_out_n;
  logic [ND-1:0] digit_sel_n;
  logic          blank_n;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;   // edges since reset released -> expected scan index

  bcd_scan_counter #(.NUM_DIGITS(ND), .SCAN_DIV(DIV), .LZB(1)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(count), .wrap(wrap), .bcd_out(bcd_out),
    .digit_sel(digit_sel), .blank(blank)
  );

  bcd_scan_counter #(.NUM_DIGITS(ND), .SCAN_DIV(DIV), .LZB(0)) dut_nolzb (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(count_n), .wrap(wrap_n), .bcd_out(bcd_out_n),
    .digit_sel(digit_sel_n), .blank(blank_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold count steady for a full scan and check each slot. blank_mask bit i
  // is the expected blank for digit i on the LZB=1 instance.
  task automatic scan_check(input logic [15:0] val, input logic [3:0] blank_mask);
    int idx;
    logic [15:0] v;
    v = val;
    for (int k = 0; k < DIV * ND; k++) begin
      tick();
      idx = (cyc / DIV) % ND;
      check("scan_sel",     32'(digit_sel), 32'(1 << idx));
      check("scan_bcd",     32'(bcd_out),   32'(v[4*idx +: 4]));
      check("scan_blank",   32'(blank),     32'(blank_mask[idx]));
      check("scan_blank_n", 32'(blank_n),   32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    tick();
    tick();
    check("rst_count", 32'(count),     32'h0000);
    check("rst_wrap",  32'(wrap),      32'd0);
    check("rst_sel",   32'(digit_sel), 32'b0001);
    check("rst_bcd",   32'(bcd_out),   32'd0);
    check("rst_blank", 32'(blank),     32'd0);
    reset = 1'b0;

    // 1. scan timing
    repeat (3) tick();
    check("sel_hold3", 32'(digit_sel), 32'b0001);
    tick();
    check("sel_adv4",  32'(digit_sel), 32'b0010);
    repeat (12) tick();
    check("sel_wrap16", 32'(digit_sel), 32'b0001);

    // 2. ripple carries
    load_val = 16'h0998; load = 1'b1;
    tick();
    load = 1'b0;
    check("ld_0998", 32'(count), 32'h0998);
    en = 1'b1; up = 1'b1;
    tick();
    check("inc_0999", 32'(count), 32'h0999);
    check("inc_0999_wrap", 32'(wrap), 32'd0);
    tick();
    check("inc_1000", 32'(count), 32'h1000);
    check("inc_1000_wrap", 32'(wrap), 32'd0);
    en = 1'b0;

    // 3. rollover both directions
    load_val = 16'h9999; load = 1'b1;
    tick();
    load = 1'b0;
    check("ld_9999", 32'(count), 32'h9999);
    en = 1'b1; up = 1'b1;
    tick();
    check("roll_up", 32'(count), 32'h0000);
    check("roll_up_wrap", 32'(wrap), 32'd1);
    up = 1'b0;
    tick();
    check("roll_dn", 32'(count), 32'h9999);
    check("roll_dn_wrap", 32'(wrap), 32'd1);
    en = 1'b0;
    tick();
    check("hold_9999", 32'(count), 32'h9999);
    check("wrap_1cyc", 32'(wrap), 32'd0);
    en = 1'b1; up = 1'b0;
    tick();
    check("dec_9998", 32'(count), 32'h9998);
    check("dec_wrap0", 32'(wrap), 32'd0);
    en = 1'b0;

    // 4. illegal nibbles clamp to 9
    load_val = 16'hFA3C; load = 1'b1;
    tick();
    load = 1'b0;
    check("ld_clamp", 32'(count), 32'h9939);
    check("ld_clamp_wrap", 32'(wrap), 32'd0);
    scan_check(16'h9939, 4'b0000);

    // 5. load beats en
    load_val = 16'h0042; load = 1'b1; en = 1'b1; up = 1'b1;
    tick();
    load = 1'b0; en = 1'b0;
    check("ld_over_en", 32'(count), 32'h0042);

    // 6. blanking with 0x0042
    scan_check(16'h0042, 4'b1100);

    // reset mid-scan at index 2
    for (int k = 0; k < 4 * DIV * ND && digit_sel != 4'b0100; k++) tick();
    check("reach_idx2", 32'(digit_sel), 32'b0100);
    reset = 1'b1;
    tick();
    check("mid_rst_count", 32'(count),     32'h0000);
    check("mid_rst_sel",   32'(digit_sel), 32'b0001);
    check("mid_rst_bcd",   32'(bcd_out),   32'd0);
    check("mid_rst_blank", 32'(blank),     32'd0);
    check("mid_rst_wrap",  32'(wrap),      32'd0);
    reset = 1'b0;

    // zero value: only digit 0 shown
    scan_check(16'h0000, 4'b1110);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
